// File: rtl/change_dispenser_pkg.sv
// Shared encodings for the change dispenser: FSM states, denomination values and
// the one-hot coin codes used on the money bus (bit0=5, bit1=10, bit2=20).
package change_dispenser_pkg;

  typedef logic [2:0] state_t;
  typedef logic [2:0] coin_sel_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_SELECT  = 3'd2;
  localparam state_t ST_REQ     = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam int DENO_5  = 5;
  localparam int DENO_10 = 10;
  localparam int DENO_20 = 20;

  localparam coin_sel_t SEL_NONE = 3'b000;
  localparam coin_sel_t SEL_5    = 3'b001;
  localparam coin_sel_t SEL_10   = 3'b010;
  localparam coin_sel_t SEL_20   = 3'b100;

  function automatic int deno_value(input coin_sel_t sel);
    case (sel)
      SEL_20:  return DENO_20;
      SEL_10:  return DENO_10;
      SEL_5:   return DENO_5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// Three saturating per-denomination coin counters with refill and single-coin
// decrement; a refill landing on the decrement cycle nets out as old - 1 + refill_cnt.
module change_dispenser_coin_inventory
  import change_dispenser_pkg::*;
#(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dec,
  input  logic [2:0]       dec_sel,
  input  logic             refill,
  input  logic [2:0]       refill_sel,
  input  logic [INV_W-1:0] refill_cnt,
  output logic [2:0]       nonzero
);

  localparam logic [INV_W:0]   MAX_EXT = {1'b0, {INV_W{1'b1}}};
  localparam logic [INV_W-1:0] MAX_CNT = {INV_W{1'b1}};

  logic [INV_W-1:0] cnt_q [3];
  logic [INV_W-1:0] cnt_d [3];
  logic [INV_W:0]   sum   [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum[i] = {1'b0, cnt_q[i]};
      if (refill && refill_sel[i]) sum[i] = sum[i] + {1'b0, refill_cnt};
      // The FSM only picks nonempty denominations; the guard keeps a stray dec harmless.
      if (dec && dec_sel[i] && (cnt_q[i] != '0)) sum[i] = sum[i] - (INV_W+1)'(1);
      cnt_d[i] = (sum[i] > MAX_EXT) ? MAX_CNT : sum[i][INV_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= INV_W'(INV_INIT);
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign nonzero = {|cnt_q[2], |cnt_q[1], |cnt_q[0]};

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: greedy 20/10/5 coin selection driving a four-phase hopper handshake.
// Define CHANGE_INVENTORY_EN to enable finite per-denomination inventory and refill.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W    = 8,
  parameter int ACK_TMO  = 255,
  parameter int INV_W    = 6,
  parameter int INV_INIT = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             ready,
  output logic             coin_req,
  output logic [2:0]       coin_sel,
  input  logic             hopper_ack,
  output logic             change_done,
  output logic             change_err,
  output logic [AMT_W-1:0] remaining,
  input  logic             refill,
  input  logic [2:0]       refill_sel,
  input  logic [INV_W-1:0] refill_cnt
);

  localparam int               TMO_W    = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
  localparam logic [AMT_W-1:0] D5       = AMT_W'(DENO_5);
  localparam logic [AMT_W-1:0] D10      = AMT_W'(DENO_10);
  localparam logic [AMT_W-1:0] D20      = AMT_W'(DENO_20);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q,   rem_d;
  coin_sel_t        sel_q,   sel_d;
  logic             err_q,   err_d;
  logic [TMO_W-1:0] tmo_q,   tmo_d;
  logic             dec;
  logic [2:0]       avail;

`ifdef CHANGE_INVENTORY_EN
  change_dispenser_coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inv (
    .clk        (clk),
    .reset_n    (reset_n),
    .dec        (dec),
    .dec_sel    (sel_q),
    .refill     (refill),
    .refill_sel (refill_sel),
    .refill_cnt (refill_cnt),
    .nonzero    (avail)
  );
`else
  // Infinite inventory: the refill interface stays on the port list but has no effect.
  logic unused_cfg;
  assign unused_cfg = (^{refill, refill_sel, refill_cnt, dec}) ^ (INV_INIT != 0);
  assign avail      = 3'b111;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (change_valid) begin
          rem_d   = change_amount;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if ((rem_q % D5) != '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmo_d   = '0;
        state_d = ST_REQ;
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if ((rem_q >= D20) && avail[2]) begin
          sel_d = SEL_20;
        end else if ((rem_q >= D10) && avail[1]) begin
          sel_d = SEL_10;
        end else if ((rem_q >= D5) && avail[0]) begin
          sel_d = SEL_5;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (hopper_ack) begin
          rem_d   = rem_q - AMT_W'(deno_value(sel_q));
          dec     = 1'b1;
          tmo_d   = '0;
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!hopper_ack) begin
          sel_d   = SEL_NONE;
          state_d = ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sel_q   <= SEL_NONE;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode the registered state, so reset drops coin_req without waiting for a clock.
  assign ready       = (state_q == ST_IDLE);
  assign coin_req    = (state_q == ST_REQ);
  assign coin_sel    = coin_req ? sel_q : SEL_NONE;
  assign change_done = (state_q == ST_DONE);
  assign change_err  = change_done & err_q;
  assign remaining   = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy-change reference model and a
// per-cycle monitor comparing coin selections and completion status against it.
module tb_change_dispenser;

  localparam int AMT_W    = 8;
  localparam int ACK_TMO  = 8;
  localparam int INV_W    = 6;
  localparam int INV_INIT = 2;
`ifdef CHANGE_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             change_valid = 1'b0;
  logic [AMT_W-1:0] change_amount = '0;
  logic             ready;
  logic             coin_req;
  logic [2:0]       coin_sel;
  logic             hopper_ack = 1'b0;
  logic             change_done;
  logic             change_err;
  logic [AMT_W-1:0] remaining;
  logic             refill = 1'b0;
  logic [2:0]       refill_sel = '0;
  logic [INV_W-1:0] refill_cnt = '0;

  change_dispenser #(
    .AMT_W(AMT_W), .ACK_TMO(ACK_TMO), .INV_W(INV_W), .INV_INIT(INV_INIT)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .change_valid(change_valid), .change_amount(change_amount),
    .ready(ready), .coin_req(coin_req), .coin_sel(coin_sel), .hopper_ack(hopper_ack),
    .change_done(change_done), .change_err(change_err), .remaining(remaining),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the dispenser owes, computed from the greedy-change rules.
  logic [2:0] exp_q[$];
  int         exp_rem = 0;
  bit         exp_err = 1'b0;
  int         m_inv[3];
  int         done_cnt = 0;
  int         done_base = 0;
  bit         ack_en = 1'b1;

  task automatic model_txn(input int amount, input bit ack_ok);
    int  rem;
    int  deno[3];
    bit  found;
    deno = '{5, 10, 20};
    exp_q.delete();
    exp_err = 1'b0;
    rem = amount;
    if (amount % 5 != 0) begin
      exp_err = 1'b1;
    end else begin
      while (rem > 0) begin
        found = 1'b0;
        for (int i = 2; i >= 0; i--) begin
          if (!found && deno[i] <= rem && (!INV_EN || m_inv[i] > 0)) begin
            found = 1'b1;
            exp_q.push_back(3'(1 << i));
            if (ack_ok) begin
              rem -= deno[i];
              m_inv[i]--;
            end
          end
        end
        if (!found || !ack_ok) begin
          exp_err = 1'b1;
          break;
        end
      end
    end
    exp_rem = rem;
  endtask

  // Hopper: acknowledges one cycle after request, releases one cycle after request drops.
  initial forever begin
    @(posedge clk);
    #1 hopper_ack = ack_en ? coin_req : 1'b0;
  end

  // Monitor: every coin offered and every completion is checked against the model.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!coin_req) check("coin_sel_idle", coin_sel, 3'b000);
        if (coin_req && !prev_req) begin
          if (exp_q.size() == 0) check("coin_unexpected", coin_sel, 3'b000);
          else check("coin_sel", coin_sel, exp_q.pop_front());
        end
        if (change_done) begin
          check("done_err", change_err, exp_err);
          check("done_remaining", remaining, exp_rem);
          check("coins_outstanding", exp_q.size(), 0);
          done_cnt++;
        end
      end
      prev_req = coin_req;
    end
  end

  task automatic start_txn(input int amount, input bit ack_ok);
    model_txn(amount, ack_ok);
    @(negedge clk);
    check("ready_before_start", ready, 1'b1);
    done_base     = done_cnt;
    change_valid  = 1'b1;
    change_amount = AMT_W'(amount);
    @(posedge clk);
    #1 change_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    #1;
    while (done_cnt <= done_base && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt <= done_base) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_coin_req();
    int n;
    n = 0;
    while (!coin_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!coin_req) check("coin_req_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;

    // Reset state
    #12;
    check("rst_ready", ready, 1'b1);
    check("rst_coin_req", coin_req, 1'b0);
    check("rst_coin_sel", coin_sel, 3'b000);
    check("rst_done", change_done, 1'b0);
    check("rst_err", change_err, 1'b0);
    check("rst_remaining", remaining, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 35 -> 20,10,5; first request three cycles after the accepted valid; busy valid ignored
    start_txn(35, 1'b1);
    check("lat_cycle1", coin_req, 1'b0);
    @(posedge clk); #1 check("lat_cycle2", coin_req, 1'b0);
    @(posedge clk); #1 check("lat_cycle3", coin_req, 1'b1);
    check("lat_sel20", coin_sel, 3'b100);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = AMT_W'(10);
    @(posedge clk);
    #1 change_valid = 1'b0;
    wait_done();
    check("amt35_done", change_done, 1'b1);
    check("amt35_err", change_err, 1'b0);
    check("amt35_rem", remaining, 0);
    check("amt35_busy_ready", ready, 1'b0);
    @(negedge clk);
    check("amt35_ready_after", ready, 1'b1);
    repeat (6) @(negedge clk);
    check("busy_valid_ignored", done_cnt, done_base + 1);

    // 0 -> done two cycles later, no coins
    start_txn(0, 1'b1);
    check("amt0_not_yet", change_done, 1'b0);
    @(posedge clk); #1 check("amt0_done", change_done, 1'b1);
    check("amt0_err", change_err, 1'b0);
    wait_done();

    // 12 -> not a multiple of five
    start_txn(12, 1'b1);
    wait_done();
    check("amt12_err", change_err, 1'b1);
    check("amt12_rem", remaining, 12);

    // Hopper silent: request held ACK_TMO cycles then abort with nothing dispensed
    ack_en = 1'b0;
    start_txn(20, 1'b0);
    wait_coin_req();
    n = 0;
    while (coin_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n, ACK_TMO);
    wait_done();
    check("tmo_err", change_err, 1'b1);
    check("tmo_rem", remaining, 20);
    ack_en = 1'b1;

`ifdef CHANGE_INVENTORY_EN
    // Drain the 20s, then 40 with one 10 and one 5 left -> shortfall of 25
    start_txn(20, 1'b1);
    wait_done();
    start_txn(40, 1'b1);
    wait_done();
    check("short40_err", change_err, 1'b1);
    check("short40_rem", remaining, 25);

    // Refill one 5, then refill ten 5s on the very cycle a 5 is taken
    @(negedge clk);
    refill = 1'b1; refill_sel = 3'b001; refill_cnt = INV_W'(1);
    @(negedge clk);
    refill = 1'b0;
    m_inv[0] += 1;
    check("refill_inv5", u_dut.u_inv.cnt_q[0], 1);
    start_txn(5, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(coin_req && hopper_ack) && n < 20);
    refill = 1'b1; refill_sel = 3'b001; refill_cnt = INV_W'(10);
    @(posedge clk); #1;
    refill = 1'b0;
    m_inv[0] += 10;
    check("refill_concurrent_inv5", u_dut.u_inv.cnt_q[0], 10);
    check("refill_model_inv5", u_dut.u_inv.cnt_q[0], m_inv[0]);
    wait_done();
`else
    // 40 -> two 20s with unlimited inventory
    start_txn(40, 1'b1);
    wait_done();
    check("amt40_err", change_err, 1'b0);
    check("amt40_rem", remaining, 0);
`endif

    // Reset while requesting: request drops immediately, nothing counted
    ack_en = 1'b0;
    start_txn(20, 1'b0);
    wait_coin_req();
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_coin_req", coin_req, 1'b0);
    check("rst_mid_ready", ready, 1'b1);
    check("rst_mid_rem", remaining, 0);
    check("rst_mid_sel", coin_sel, 3'b000);
`ifdef CHANGE_INVENTORY_EN
    for (int i = 0; i < 3; i++) check("rst_mid_inv", u_dut.u_inv.cnt_q[i], INV_INIT);
`endif
    exp_q.delete();
    for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
    ack_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Normal operation after reset: 15 -> 10,5
    start_txn(15, 1'b1);
    wait_done();
    check("amt15_err", change_err, 1'b0);
    check("amt15_rem", remaining, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
